// File: rtl/dbg_arb_pkg.sv
// rtl/dbg_arb_pkg.sv - shared types and constants for the debug port arbiter
package dbg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int REQ_VGA    = 0;
  localparam int REQ_AUX    = 1;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/dbg_port_arbiter_if.sv
// rtl/dbg_port_arbiter_if.sv - requester, response and core debug port bundle
interface dbg_port_arbiter_if
  import dbg_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic              gnt0;
  logic              gnt1;
  logic              rsp_valid0;
  logic              rsp_valid1;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              busy;

  modport slave (
    input  req0, req1, addr0, addr1, dbg_data,
    output gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_data, dbg_addr, busy
  );

  modport master (
    output req0, req1, addr0, addr1, dbg_data,
    input  gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_data, dbg_addr, busy
  );

endinterface

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin selector producing a one-hot winner
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    if (req[ptr]) begin
      win[ptr] = 1'b1;
    end else if (req[~ptr]) begin
      win[~ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/dbg_port_arbiter.sv
// rtl/dbg_port_arbiter.sv - round-robin sharing of the core debug read port
// Optional grant counters cnt0/cnt1 with cnt_clr are built when DBG_ARB_PERF_EN is defined.
module dbg_port_arbiter
  import dbg_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
`ifdef DBG_ARB_PERF_EN
  input  logic        cnt_clr,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1,
`endif
  dbg_port_arbiter_if.slave bus
);

  localparam logic [2:0] HOLD_INIT = 3'(READ_LAT - 1);

  arb_state_t        state;
  logic [2:0]        hold_cnt;
  logic              ptr;
  logic              owner;
  logic              gnt0_q;
  logic              gnt1_q;
  logic              rsp_valid0_q;
  logic              rsp_valid1_q;
  logic              busy_q;
  logic [ADDR_W-1:0] dbg_addr_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [1:0]        req_vec;
  logic [1:0]        win;

  assign req_vec = {bus.req1, bus.req0};

  rr_pick2 u_pick (
    .req (req_vec),
    .ptr (ptr),
    .win (win)
  );

  // Outputs are registered, so each one becomes visible a cycle after the
  // state transition that sets it: rsp_valid shows in the cycle after RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      hold_cnt     <= 3'd0;
      ptr          <= 1'b0;
      owner        <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      busy_q       <= 1'b0;
      dbg_addr_q   <= '0;
      rsp_data_q   <= '0;
    end else begin
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_vec) begin
            dbg_addr_q <= win[REQ_AUX] ? bus.addr1 : bus.addr0;
            gnt0_q     <= win[REQ_VGA];
            gnt1_q     <= win[REQ_AUX];
            owner      <= win[REQ_AUX];
            ptr        <= ~win[REQ_AUX];
            busy_q     <= 1'b1;
            hold_cnt   <= HOLD_INIT;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt == 3'd0) begin
            rsp_data_q <= bus.dbg_data;
            state      <= RESP;
          end else begin
            hold_cnt <= hold_cnt - 3'd1;
          end
        end
        RESP: begin
          rsp_valid0_q <= ~owner;
          rsp_valid1_q <= owner;
          busy_q       <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0       = gnt0_q;
  assign bus.gnt1       = gnt1_q;
  assign bus.rsp_valid0 = rsp_valid0_q;
  assign bus.rsp_valid1 = rsp_valid1_q;
  assign bus.busy       = busy_q;
  assign bus.dbg_addr   = dbg_addr_q;
  assign bus.rsp_data   = rsp_data_q;

`ifdef DBG_ARB_PERF_EN
  logic grant_ev;

  assign grant_ev = (state == IDLE) && (|req_vec);

  // Clear takes priority over a coincident grant; counts saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= 16'd0;
      cnt1 <= 16'd0;
    end else if (cnt_clr) begin
      cnt0 <= 16'd0;
      cnt1 <= 16'd0;
    end else if (grant_ev) begin
      if (win[REQ_VGA] && (cnt0 != 16'hFFFF)) begin
        cnt0 <= cnt0 + 16'd1;
      end
      if (win[REQ_AUX] && (cnt1 != 16'hFFFF)) begin
        cnt1 <= cnt1 + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dbg_port_arbiter.sv
// tb/tb_dbg_port_arbiter.sv - scoreboard bench for dbg_port_arbiter (READ_LAT 1 and 3)
module tb_dbg_port_arbiter;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  dbg_port_arbiter_if #(.ADDR_W(7), .DATA_W(32)) b1 ();
  dbg_port_arbiter_if #(.ADDR_W(7), .DATA_W(32)) b3 ();

`ifdef DBG_ARB_PERF_EN
  logic        cnt_clr;
  logic [15:0] cnt0;
  logic [15:0] cnt1;
  logic [15:0] cnt0_3;
  logic [15:0] cnt1_3;
`endif

  dbg_port_arbiter #(.ADDR_W(7), .DATA_W(32), .READ_LAT(1)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
`ifdef DBG_ARB_PERF_EN
    .cnt_clr (cnt_clr),
    .cnt0    (cnt0),
    .cnt1    (cnt1),
`endif
    .bus     (b1)
  );

  dbg_port_arbiter #(.ADDR_W(7), .DATA_W(32), .READ_LAT(3)) u_dut3 (
    .clk     (clk),
    .rst     (rst),
`ifdef DBG_ARB_PERF_EN
    .cnt_clr (1'b0),
    .cnt0    (cnt0_3),
    .cnt1    (cnt1_3),
`endif
    .bus     (b3)
  );

  function automatic logic [31:0] core_mem(input logic [6:0] a);
    return (a == 7'h05) ? 32'hDEAD_BEEF : {16'hC0DE, 9'h000, a};
  endfunction

  logic [31:0] sweep_data;
  assign b1.dbg_data = core_mem(b1.dbg_addr);
  assign b3.dbg_data = sweep_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int          plan0, plan1, issued0, issued1, plan3, issued3;
  bit          hold0;
  int          hold_gnts0;
  int          inflight1;
  int          raise0, raise3, g3;
  bit          g3_seen;
  bit          use_fixed0;
  logic [6:0]  fixed_addr0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q3[$];
  int          gnt_id[$];
  int          gnt_cyc[$];
  int          rsp_cyc[$];
  int          rsp1_cnt;
  int          rsp_total;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requester agents plus response scoreboard for both arbiters.
  task automatic agent_mon();
    forever begin
      @(negedge clk);
      if (rst) begin
        b1.req0 = 1'b0;
        b1.req1 = 1'b0;
        b3.req0 = 1'b0;
        q0.delete();
        q1.delete();
        q3.delete();
        inflight1 = 0;
        g3_seen = 1'b0;
      end else begin
        if (b1.gnt0 || b1.gnt1) begin
          check("no_dbl_gnt", 64'(inflight1), 64'd0);
          check("gnt_excl", 64'(b1.gnt0 & b1.gnt1), 64'd0);
          check("gnt_addr", 64'(b1.dbg_addr), 64'(b1.gnt1 ? b1.addr1 : b1.addr0));
          inflight1 = 1;
          gnt_id.push_back(b1.gnt1 ? 1 : 0);
          gnt_cyc.push_back(cyc);
        end
        if (b1.rsp_valid0 || b1.rsp_valid1) begin
          rsp_total++;
          rsp_cyc.push_back(cyc);
          if (b1.rsp_valid1) rsp1_cnt++;
          check("rsp_excl", 64'(b1.rsp_valid0 & b1.rsp_valid1), 64'd0);
          if (inflight1 == 0) begin
            check("rsp_unexp", 64'd1, 64'd0);
          end else begin
            check("rsp_lat", 64'(cyc - gnt_cyc[gnt_cyc.size()-1]), 64'd2);
            check("rsp_owner", 64'(b1.rsp_valid1), 64'(gnt_id[gnt_id.size()-1]));
          end
          if (b1.rsp_valid0) begin
            if (q0.size() == 0) check("rsp0_extra", 64'd1, 64'd0);
            else check("rsp0_data", 64'(b1.rsp_data), 64'(q0.pop_front()));
          end
          if (b1.rsp_valid1) begin
            if (q1.size() == 0) check("rsp1_extra", 64'd1, 64'd0);
            else check("rsp1_data", 64'(b1.rsp_data), 64'(q1.pop_front()));
          end
          inflight1 = 0;
        end
        if (b1.gnt0) begin
          if (hold0) begin
            hold_gnts0++;
            if (hold_gnts0 == 3) b1.req0 = 1'b0;
          end else begin
            b1.req0 = 1'b0;
          end
        end else if (!b1.req0 && issued0 < plan0) begin
          b1.addr0 = use_fixed0 ? fixed_addr0 : 7'($urandom_range(0, 127));
          b1.req0 = 1'b1;
          raise0 = cyc;
          issued0++;
          if (hold0) begin
            hold_gnts0 = 0;
            repeat (3) q0.push_back(core_mem(b1.addr0));
          end else begin
            q0.push_back(core_mem(b1.addr0));
          end
        end
        if (b1.gnt1) begin
          b1.req1 = 1'b0;
        end else if (!b1.req1 && issued1 < plan1) begin
          b1.addr1 = 7'($urandom_range(0, 127));
          b1.req1 = 1'b1;
          issued1++;
          q1.push_back(core_mem(b1.addr1));
        end
        if (b3.gnt0) begin
          check("gnt3_lat", 64'(cyc - raise3), 64'd1);
          b3.req0 = 1'b0;
          g3 = cyc;
          g3_seen = 1'b1;
        end else if (!b3.req0 && issued3 < plan3) begin
          b3.addr0 = 7'h11;
          sweep_data = 32'h1111_1111;
          b3.req0 = 1'b1;
          raise3 = cyc;
          issued3++;
          q3.push_back(32'h2222_2222);
        end
        if (g3_seen && cyc == g3 + 1) sweep_data = 32'h2222_2222;
        if (b3.gnt1 || b3.rsp_valid1) check("dut3_side1", 64'd1, 64'd0);
        if (b3.rsp_valid0) begin
          check("rsp3_lat", 64'(cyc - g3), 64'd4);
          if (q3.size() == 0) check("rsp3_extra", 64'd1, 64'd0);
          else check("rsp3_data", 64'(b3.rsp_data), 64'(q3.pop_front()));
          g3_seen = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!(issued0 == plan0 && issued1 == plan1 && !b1.req0 && !b1.req1 &&
             q0.size() == 0 && q1.size() == 0 && !b1.busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check(tag, 64'd0, 64'd1);
    @(negedge clk);
  endtask

  initial begin
    int base;
    int rb;
    int rc;
    int n;
    total = 0; bad = 0; cyc = 0;
    rst = 1'b1;
    plan0 = 0; plan1 = 0; issued0 = 0; issued1 = 0; plan3 = 0; issued3 = 0;
    hold0 = 1'b0; hold_gnts0 = 0; inflight1 = 0; raise0 = 0; raise3 = 0; g3 = 0;
    g3_seen = 1'b0; use_fixed0 = 1'b0; fixed_addr0 = 7'h05; rsp1_cnt = 0; rsp_total = 0;
    sweep_data = 32'h1111_1111;
    b1.req0 = 1'b0; b1.req1 = 1'b0; b1.addr0 = '0; b1.addr1 = '0;
    b3.req0 = 1'b0; b3.req1 = 1'b0; b3.addr0 = '0; b3.addr1 = '0;
`ifdef DBG_ARB_PERF_EN
    cnt_clr = 1'b0;
`endif
    fork
      agent_mon();
    join_none

    repeat (3) @(negedge clk);
    check("rst_gnt0", 64'(b1.gnt0), 64'd0);
    check("rst_gnt1", 64'(b1.gnt1), 64'd0);
    check("rst_rv0", 64'(b1.rsp_valid0), 64'd0);
    check("rst_rv1", 64'(b1.rsp_valid1), 64'd0);
    check("rst_busy", 64'(b1.busy), 64'd0);
    check("rst_addr", 64'(b1.dbg_addr), 64'd0);
    check("rst_data", 64'(b1.rsp_data), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // contention straight out of reset
    base = gnt_id.size();
    plan0 = 2; plan1 = 2;
    wait_done("t_cont_timeout", 80);
    check("cont_ngnt", 64'(gnt_id.size() - base), 64'd4);
    if (gnt_id.size() - base == 4) begin
      for (int k = 0; k < 4; k++) check("cont_order", 64'(gnt_id[base+k]), 64'(k % 2));
      for (int k = 1; k < 4; k++) check("cont_gap", 64'(gnt_cyc[base+k] - gnt_cyc[base+k-1]), 64'd3);
    end

    // single read of address 5
    base = gnt_id.size();
    rc = rsp1_cnt;
    use_fixed0 = 1'b1;
    plan0 = plan0 + 1;
    wait_done("t_single_timeout", 40);
    use_fixed0 = 1'b0;
    check("single_ngnt", 64'(gnt_id.size() - base), 64'd1);
    if (gnt_id.size() > base) begin
      check("single_id", 64'(gnt_id[base]), 64'd0);
      check("single_gnt_lat", 64'(gnt_cyc[base] - raise0), 64'd1);
    end
    check("single_no_rv1", 64'(rsp1_cnt - rc), 64'd0);

    // req0 held high across three transactions
    base = gnt_id.size();
    rb = rsp_cyc.size();
    hold0 = 1'b1;
    plan0 = plan0 + 1;
    wait_done("t_hold_timeout", 60);
    hold0 = 1'b0;
    check("hold_ngnt", 64'(gnt_id.size() - base), 64'd3);
    if (gnt_id.size() - base == 3 && rsp_cyc.size() - rb == 3) begin
      for (int k = 1; k < 3; k++) begin
        check("hold_after_rsp", 64'((gnt_cyc[base+k] - rsp_cyc[rb+k-1]) >= 1), 64'd1);
        check("hold_gap", 64'(gnt_cyc[base+k] - gnt_cyc[base+k-1]), 64'd3);
      end
    end

    // READ_LAT=3 with data changing during HOLD
    plan3 = 1;
    n = 0;
    while (!(issued3 == plan3 && !b3.req0 && q3.size() == 0 && !b3.busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("t_lat3_timeout", 64'd0, 64'd1);

    // reset while a read is in flight
    n = 0;
    plan0 = plan0 + 1;
    @(negedge clk);
    while (!b1.gnt0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("t_rst_timeout", 64'd0, 64'd1);
    check("rst_mid_busy_pre", 64'(b1.busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_gnt0", 64'(b1.gnt0), 64'd0);
    check("rst_async_busy", 64'(b1.busy), 64'd0);
    check("rst_async_rv0", 64'(b1.rsp_valid0), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    rc = rsp_total;
    repeat (6) @(negedge clk);
    check("rst_no_rsp", 64'(rsp_total - rc), 64'd0);
    base = gnt_id.size();
    plan0 = plan0 + 1; plan1 = plan1 + 1;
    wait_done("t_post_rst_timeout", 40);
    check("post_rst_ngnt", 64'(gnt_id.size() - base), 64'd2);
    if (gnt_id.size() > base) begin
      check("post_rst_first", 64'(gnt_id[base]), 64'd0);
      check("post_rst_lat", 64'(gnt_cyc[base] - raise0), 64'd1);
    end

`ifdef DBG_ARB_PERF_EN
    @(posedge clk);
    #1 cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    plan0 = plan0 + 3; plan1 = plan1 + 2;
    wait_done("t_perf_timeout", 80);
    check("perf_cnt0", 64'(cnt0), 64'd3);
    check("perf_cnt1", 64'(cnt1), 64'd2);
    @(posedge clk);
    #1 cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    @(negedge clk);
    check("perf_clr0", 64'(cnt0), 64'd0);
    check("perf_clr1", 64'(cnt1), 64'd0);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
